// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit sitting directly in front of a word-addressed data
// memory (combinational read, write on posedge when mem_WE). Loads return
// sign/zero-extended bytes and halves; SB/SH are done as read-modify-write.
// Misaligned, illegal and out-of-range requests complete with fault=1 and
// never touch memory.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_funct3       store/load select, RISC-V access size/sign code
//   req_addr, req_wdata      byte address, store data (low byte/half for SB/SH)
//   rsp_valid, rsp_rdata     one-cycle completion pulse, extended load data
//   fault                    request faulted (qualified by rsp_valid)
//   mem_A, mem_WE, mem_WD    memory address (word aligned), write enable, data
//   mem_RD                   memory read data
module lsu_rmw #(
  parameter int DEPTH_LOG2  = 10,
  parameter int CHECK_RANGE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        fault,
  output logic [31:0] mem_A,
  output logic        mem_WE,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, DONE} state_t;

  state_t      state_reg;
  logic [1:0]  addr_lo_reg;   // byte offset within the word
  logic [2:0]  funct3_reg;
  logic        fault_reg;
  logic [31:0] wd_reg;        // store data, replaced by the merged word in READ
  logic [31:0] rdata_reg;
  logic [31:0] a_reg;

  // Request checks, evaluated on the raw request in IDLE.
  logic illegal, misaligned, range_bad, req_fault;

  always_comb begin
    if (req_we)
      illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
    else
      illegal = (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
    misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    range_bad  = (CHECK_RANGE != 0) && ((req_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    req_fault  = illegal || misaligned || range_bad;
  end

  // Load lane selection and extension (little-endian: byte 0 = bits 7:0).
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    case (addr_lo_reg)
      2'd0:    ld_byte = mem_RD[7:0];
      2'd1:    ld_byte = mem_RD[15:8];
      2'd2:    ld_byte = mem_RD[23:16];
      default: ld_byte = mem_RD[31:24];
    endcase
    ld_half = addr_lo_reg[1] ? mem_RD[31:16] : mem_RD[15:0];
    case (funct3_reg)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_RD;
    endcase
  end

  // Sub-word store merge: each byte lane takes the new data if the access
  // covers it, otherwise keeps the current memory contents.
  logic [31:0] merged;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic byte_hit, half_hit;
      assign byte_hit = (funct3_reg[1:0] == 2'b00) && (addr_lo_reg == 2'(gi));
      assign half_hit = (funct3_reg[1:0] == 2'b01) && (addr_lo_reg[1] == 1'(gi / 2));
      assign merged[8*gi +: 8] = byte_hit ? wd_reg[7:0] :
                                 half_hit ? wd_reg[8*(gi % 2) +: 8] :
                                            mem_RD[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_lo_reg <= 2'd0;
      funct3_reg  <= 3'd0;
      fault_reg   <= 1'b0;
      wd_reg      <= 32'd0;
      rdata_reg   <= 32'd0;
      a_reg       <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_lo_reg <= req_addr[1:0];
            funct3_reg  <= req_funct3;
            wd_reg      <= req_wdata;
            a_reg       <= {req_addr[31:2], 2'b00};
            fault_reg   <= req_fault;
            rdata_reg   <= 32'd0;
            if (req_fault)
              state_reg <= DONE;
            else if (!req_we)
              state_reg <= LOAD;
            else if (req_funct3 == 3'b010)
              state_reg <= WRITE;
            else
              state_reg <= READ;
          end
        end
        LOAD: begin
          rdata_reg <= ld_ext;
          state_reg <= DONE;
        end
        READ: begin
          wd_reg    <= merged;
          state_reg <= WRITE;
        end
        WRITE:   state_reg <= DONE;
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The write strobe is masked by rst so a reset landing on WRITE cannot
  // commit a half-finished read-modify-write.
  assign mem_WE    = (state_reg == WRITE) && !rst;
  assign mem_WD    = mem_WE ? wd_reg : 32'd0;
  assign mem_A     = a_reg;
  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == DONE);
  assign fault     = rsp_valid && fault_reg;
  assign rsp_rdata = rdata_reg;

endmodule

// File: tb/tb_lsu_rmw.sv
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, fault;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;

  always #5 clk = ~clk;

  lsu_rmw #(.DEPTH_LOG2(10), .CHECK_RANGE(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
    .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  // Data memory: 1024 x 32, combinational read, posedge write.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = 10'd0;
  logic [31:0] pl_data = 32'd0;
  assign mem_RD = mem[mem_A[11:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_WE) mem[mem_A[11:2]] <= mem_WD;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;
  int we_cnt  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        flt;
    int          acc;
    int          lat;
    int          nwr;
    logic [31:0] wd;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        flt;
    int          lat;
    int          nwr;
    logic [31:0] wd;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Response monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_WE) begin
        we_cnt++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: mem_WE=1 with nothing outstanding at cycle %0d", cyc);
        end else begin
          chk("mem_WD", mem_WD, sb[0].wd);
        end
      end else if (mem_WD !== 32'd0) begin
        errors++;
        $display("FAIL wd_idle: got %h expected 00000000", mem_WD);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("fault", {31'd0, fault}, {31'd0, e.flt});
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          chk("write_count", 32'(we_cnt), 32'(e.nwr));
          $display("rsp: rdata=%h fault=%0b latency=%0d writes=%0d", rsp_rdata, fault, cyc - e.acc + 1, we_cnt);
        end
        we_cnt = 0;
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] data);
    pl_idx = 10'(idx); pl_data = data; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drive a request (called at a negedge) and leave req_valid high; returns
  // the cycle number of the accepting edge, or -1 on timeout.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata_exp,
                      input logic flt_exp, input int lat, input int nwr,
                      input logic [31:0] wd_exp, output int acc);
    exp_t e;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=0 expected 1 for addr %h", addr);
      acc = -1;
      return;
    end
    acc = cyc + 1;
    e = '{rdata: rdata_exp, flt: flt_exp, acc: acc, lat: lat, nwr: nwr, wd: wd_exp};
    sb.push_back(e);
    $display("req: we=%0b funct3=%03b addr=%h wdata=%h", we, f3, addr, wdata);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && (sb.size() != 0 || !req_ready); i++) @(negedge clk);
    if (sb.size() != 0 || !req_ready) begin
      errors++;
      $display("FAIL rsp_timeout: outstanding=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    repeat (2) @(negedge clk);
    preload(28, 32'h0000_0020);
    preload(40, 32'h0000_80F2);
    preload(5,  32'h1122_3344);
    preload(8,  32'h5566_7788);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_fault", {31'd0, fault}, 32'd0);
    chk("reset_we", {31'd0, mem_WE}, 32'd0);
    chk("reset_mem_A", mem_A, 32'd0);
    chk("reset_mem_WD", mem_WD, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);

    //         we    f3      addr          wdata          rdata          flt lat nwr wd
    tbl[0]  = '{1'b0, 3'b010, 32'h70,       32'h0,         32'h0000_0020, 0, 2, 0, 32'h0};
    tbl[1]  = '{1'b0, 3'b000, 32'hA0,       32'h0,         32'hFFFF_FFF2, 0, 2, 0, 32'h0};
    tbl[2]  = '{1'b0, 3'b100, 32'hA0,       32'h0,         32'h0000_00F2, 0, 2, 0, 32'h0};
    tbl[3]  = '{1'b0, 3'b001, 32'hA0,       32'h0,         32'hFFFF_80F2, 0, 2, 0, 32'h0};
    tbl[4]  = '{1'b0, 3'b101, 32'hA2,       32'h0,         32'h0000_0000, 0, 2, 0, 32'h0};
    tbl[5]  = '{1'b1, 3'b000, 32'h16,       32'hAABB_CCDD, 32'h0,         0, 3, 1, 32'h11DD_3344};
    tbl[6]  = '{1'b0, 3'b010, 32'h14,       32'h0,         32'h11DD_3344, 0, 2, 0, 32'h0};
    tbl[7]  = '{1'b1, 3'b001, 32'h21,       32'hFFFF_FFFF, 32'h0,         1, 1, 0, 32'h0};
    tbl[8]  = '{1'b0, 3'b010, 32'h20,       32'h0,         32'h5566_7788, 0, 2, 0, 32'h0};
    tbl[9]  = '{1'b0, 3'b010, 32'h22,       32'h0,         32'h0,         1, 1, 0, 32'h0};
    tbl[10] = '{1'b0, 3'b011, 32'h0,        32'h0,         32'h0,         1, 1, 0, 32'h0};
    tbl[11] = '{1'b1, 3'b010, 32'h1000,     32'h1234_5678, 32'h0,         1, 1, 0, 32'h0};
    tbl[12] = '{1'b1, 3'b001, 32'hA2,       32'h1234_BEEF, 32'h0,         0, 3, 1, 32'hBEEF_80F2};
    tbl[13] = '{1'b0, 3'b001, 32'hA2,       32'h0,         32'hFFFF_BEEF, 0, 2, 0, 32'h0};
    tbl[14] = '{1'b0, 3'b000, 32'hA3,       32'h0,         32'hFFFF_FFBE, 0, 2, 0, 32'h0};
    tbl[15] = '{1'b1, 3'b100, 32'h40,       32'hDEAD_BEEF, 32'h0,         1, 1, 0, 32'h0};
    tbl[16] = '{1'b1, 3'b010, 32'h40,       32'hCAFE_F00D, 32'h0,         0, 2, 1, 32'hCAFE_F00D};
    tbl[17] = '{1'b0, 3'b101, 32'h42,       32'h0,         32'h0000_CAFE, 0, 2, 0, 32'h0};

    for (int i = 0; i < 18; i++) begin
      send(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
           tbl[i].flt, tbl[i].lat, tbl[i].nwr, tbl[i].wd, a);
      req_valid = 1'b0;
      wait_idle();
    end
    chk("mem_word8_after_fault", mem[8], 32'h5566_7788);
    chk("mem_word1024_alias_untouched", mem[0], 32'h0);

    // Reset landing in the READ cycle of an SB must abort without writing.
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h16; req_wdata = 32'h0000_00EE;
    req_valid = 1'b1;
    $display("req: SB addr=00000016 wdata=000000ee (reset in READ)");
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_mem_A", mem_A, 32'h14);
    chk("rmw_ready_busy", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_we", {31'd0, mem_WE}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_rst_mem_A", mem_A, 32'd0);
    chk("post_rst_mem_WD", mem_WD, 32'd0);
    chk("post_rst_rdata", rsp_rdata, 32'd0);
    chk("post_rst_word5", mem[5], 32'h11DD_3344);
    chk("post_rst_we_cnt", 32'(we_cnt), 32'd0);

    // Back-to-back with req_valid held high: SW then LW to the same word.
    send(1'b1, 3'b010, 32'h80, 32'h89AB_CDEF, 32'h0, 1'b0, 2, 1, 32'h89AB_CDEF, a);
    send(1'b0, 3'b010, 32'h80, 32'h0, 32'h89AB_CDEF, 1'b0, 2, 0, 32'h0, b);
    req_valid = 1'b0;
    wait_idle();
    chk("b2b_accept_gap", 32'(b - a), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
